// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM request path.
//   state_e      : request-queue sequencer states
//   CMD_READ/WRITE: command encoding on req_cmd / c_cmd
//   addr_width() : {bank,row,col} address width from geometry
//   cnt_width()  : width of a down-counter that must hold the value n
package dram_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2
  } state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  function automatic int unsigned addr_width(input int unsigned banks,
                                             input int unsigned rows,
                                             input int unsigned cols);
    return $clog2(banks) + $clog2(rows) + $clog2(cols);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers (full = MSBs differ, LSBs equal).
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i / wdata_i  : write strobe and data; push while full only lands
//                       when a pop happens in the same cycle
//   pop_i / rdata_o   : read strobe and head-of-queue data (show-ahead)
//   full_o, empty_o   : status flags
//   count_o           : occupancy, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/dram_req_queue.sv
// Host-side request buffer in front of the DRAM controller. Requests are
// queued, issued one at a time in order, and read data comes back through
// a one-entry response register guarded by a read-timeout watchdog.
// Ports:
//   u_clk, u_rst                  : clock, synchronous active-high reset
//   req_valid/req_ready/req_cmd/req_addr/req_wdata : host request channel
//   rsp_valid/rsp_ready/rsp_rdata : host read-response channel
//   rsp_err                       : sticky read-timeout flag
//   c_en/c_cmd/c_addr/c_wdata     : request presented to the controller
//   c_cmd_ack/c_busy              : controller accept / not-ready
//   c_rdata/c_data_valid          : controller read return (1-cycle pulse)
//   q_count                       : queue occupancy
//
// state     | meaning
// S_IDLE    | nothing outstanding; issue head when allowed
// S_ISSUE   | c_en high, payload held until c_cmd_ack
// S_WAIT_RD | read acked, waiting for c_data_valid or timeout
module dram_req_queue import dram_pkg::*; #(
  parameter int unsigned NUMBER_OF_COLUMNS = 8,
  parameter int unsigned NUMBER_OF_ROWS    = 128,
  parameter int unsigned NUMBER_OF_BANKS   = 8,
  parameter int unsigned U_ADDR_WIDTH      =
    addr_width(NUMBER_OF_BANKS, NUMBER_OF_ROWS, NUMBER_OF_COLUMNS),
  parameter int unsigned U_DATA_WIDTH      = 8,
  parameter int unsigned QUEUE_DEPTH       = 4,
  parameter int unsigned RD_TIMEOUT        = 64
) (
  input  logic                          u_clk,
  input  logic                          u_rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_cmd,
  input  logic [U_ADDR_WIDTH-1:0]       req_addr,
  input  logic [U_DATA_WIDTH-1:0]       req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [U_DATA_WIDTH-1:0]       rsp_rdata,
  output logic                          rsp_err,
  output logic                          c_en,
  output logic                          c_cmd,
  output logic [U_ADDR_WIDTH-1:0]       c_addr,
  output logic [U_DATA_WIDTH-1:0]       c_wdata,
  input  logic                          c_cmd_ack,
  input  logic                          c_busy,
  input  logic [U_DATA_WIDTH-1:0]       c_rdata,
  input  logic                          c_data_valid,
  output logic [$clog2(QUEUE_DEPTH):0]  q_count
);

  localparam int unsigned FW = 1 + U_ADDR_WIDTH + U_DATA_WIDTH;
  localparam int unsigned TW = cnt_width(RD_TIMEOUT);

  state_e                  state_q, state_d;
  logic                    cmd_q, cmd_d;
  logic [U_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [U_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [U_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [TW-1:0]           tmr_q, tmr_d;

  logic [FW-1:0] head;
  logic          fifo_full, fifo_empty, push, pop;

  assign req_ready = !fifo_full;
  assign push      = req_valid && !fifo_full;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk_i   (u_clk),
    .rst_i   (u_rst),
    .push_i  (push),
    .wdata_i ({req_cmd, req_addr, req_wdata}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (q_count)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    tmr_d       = tmr_q;
    pop         = 1'b0;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Waiting on !rsp_valid keeps at most one read in flight and lets
        // an unconsumed response back-pressure the whole queue.
        if (!fifo_empty && !c_busy && !rsp_valid_q) begin
          {cmd_d, addr_d, wdata_d} = head;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (c_cmd_ack) begin
          pop = 1'b1;
          if (cmd_q == CMD_WRITE) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_RD;
            tmr_d   = TW'(RD_TIMEOUT);
          end
        end
      end
      S_WAIT_RD: begin
        if (c_data_valid) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = c_rdata;
          state_d     = S_IDLE;
        end else if (tmr_q <= TW'(1)) begin
          // Terminal count: the response fires RD_TIMEOUT cycles after ack.
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge u_clk) begin
    if (u_rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tmr_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      tmr_q       <= tmr_d;
    end
  end

  assign c_en      = (state_q == S_ISSUE);
  assign c_cmd     = cmd_q;
  assign c_addr    = addr_q;
  assign c_wdata   = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dram_req_queue.sv
module tb_dram_req_queue;

  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  typedef struct packed {
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic          u_clk, u_rst;
  logic          req_valid, req_ready, req_cmd;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          c_en, c_cmd, c_cmd_ack, c_busy, c_data_valid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic [2:0]    q_count;

  dram_req_queue dut (
    .u_clk        (u_clk),
    .u_rst        (u_rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cmd      (req_cmd),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .c_en         (c_en),
    .c_cmd        (c_cmd),
    .c_addr       (c_addr),
    .c_wdata      (c_wdata),
    .c_cmd_ack    (c_cmd_ack),
    .c_busy       (c_busy),
    .c_rdata      (c_rdata),
    .c_data_valid (c_data_valid),
    .q_count      (q_count)
  );

  initial u_clk = 1'b0;
  always #5 u_clk = ~u_clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  // Reference model: a queue of pending requests, the request on the wire,
  // an outstanding-read deadline expressed in absolute cycles, and the
  // response slot.
  req_t          mq[$];
  req_t          m_cur, m_new;
  bit            m_issued, m_waiting, m_rsp_v, m_err, m_push, m_rv_old;
  logic [DW-1:0] m_rsp_d;
  int            m_deadline;
  int            cyc = 0;

  always @(posedge u_clk) begin
    if (u_rst) begin
      mq.delete();
      m_cur     = '0;
      m_issued  = 0;
      m_waiting = 0;
      m_rsp_v   = 0;
      m_rsp_d   = '0;
      m_err     = 0;
    end else begin
      m_push   = req_valid && (mq.size() < DEPTH);
      m_new    = {req_cmd, req_addr, req_wdata};
      m_rv_old = m_rsp_v;
      if (m_rsp_v && rsp_ready) m_rsp_v = 0;
      if (m_issued) begin
        if (c_cmd_ack) begin
          mq.delete(0);
          m_issued = 0;
          if (!m_cur.cmd) begin
            m_waiting  = 1;
            m_deadline = cyc + TMO;
          end
        end
      end else if (m_waiting) begin
        if (c_data_valid) begin
          m_rsp_v   = 1;
          m_rsp_d   = c_rdata;
          m_waiting = 0;
        end else if (cyc == m_deadline) begin
          m_rsp_v   = 1;
          m_rsp_d   = '0;
          m_err     = 1;
          m_waiting = 0;
        end
      end else if (mq.size() > 0 && !c_busy && !m_rv_old) begin
        m_issued = 1;
        m_cur    = mq[0];
      end
      if (m_push) mq.push_back(m_new);
    end
    cyc = cyc + 1;
  end

  always @(negedge u_clk) begin
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
      check("q_count",   32'(q_count),   32'(mq.size()));
      check("c_en",      32'(c_en),      32'(m_issued));
      check("c_cmd",     32'(c_cmd),     32'(m_cur.cmd));
      check("c_addr",    32'(c_addr),    32'(m_cur.addr));
      check("c_wdata",   32'(c_wdata),   32'(m_cur.data));
      check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
      check("rsp_rdata", 32'(rsp_rdata), 32'(m_rsp_d));
      check("rsp_err",   32'(rsp_err),   32'(m_err));
    end
  end

  // Controller stand-in: ack in the second cycle of c_en, return read data
  // rd_lat cycles after the ack (rd_lat==0 means never).
  int            rd_lat, rd_timer, en_age;
  logic [DW-1:0] rd_data;
  bit            dv_pulse;

  task automatic step();
    logic ack_was, cmd_was;
    ack_was = c_cmd_ack;
    cmd_was = c_cmd;
    @(posedge u_clk);
    #1;
    c_data_valid = 1'b0;
    if (u_rst) rd_timer = 0;
    if (dv_pulse) begin
      c_data_valid = 1'b1;
      c_rdata      = 8'hEE;
      dv_pulse     = 0;
    end
    if (rd_timer > 0) begin
      rd_timer--;
      if (rd_timer == 0) begin
        c_data_valid = 1'b1;
        c_rdata      = rd_data;
      end
    end
    if (ack_was && !cmd_was && !u_rst && rd_lat > 1) rd_timer = rd_lat - 1;
    en_age    = c_en ? en_age + 1 : 0;
    c_cmd_ack = c_en && (en_age == 2);
  endtask

  task automatic push(input logic cmd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_addr  = a;
    req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_ack(input string nm);
    int n;
    n = 0;
    while (!c_cmd_ack && n < 10) begin step(); n++; end
    check(nm, 32'(c_cmd_ack), 32'd1);
  endtask

  task automatic wait_en(input string nm);
    int n;
    n = 0;
    while (!c_en && n < 10) begin step(); n++; end
    check(nm, 32'(c_en), 32'd1);
  endtask

  initial begin
    int n;
    u_rst = 1'b1; req_valid = 1'b0; req_cmd = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; c_cmd_ack = 1'b0; c_busy = 1'b0; c_rdata = '0; c_data_valid = 1'b0;
    rd_lat = 3; rd_data = 8'h5A; rd_timer = 0; en_age = 0; dv_pulse = 0;

    // reset then idle
    step(); step();
    u_rst  = 1'b0;
    chk_en = 1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_c_en",      32'(c_en),      32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_q_count",   32'(q_count),   32'd0);

    // single write: c_en two cycles after push, held until ack
    push(1'b1, 13'h0A5, 8'h3C);
    check("wr_q_count_1", 32'(q_count), 32'd1);
    step();
    check("wr_c_en",    32'(c_en),    32'd1);
    check("wr_c_addr",  32'(c_addr),  32'h0A5);
    check("wr_c_wdata", 32'(c_wdata), 32'h3C);
    step(); step();
    check("wr_c_en_drop", 32'(c_en),    32'd0);
    check("wr_q_count_0", 32'(q_count), 32'd0);
    step(); step(); step();
    check("wr_no_rsp", 32'(rsp_valid), 32'd0);

    // read round trip with a held response blocking the next request
    rsp_ready = 1'b0;
    push(1'b0, 13'h1FF, 8'h00);
    push(1'b1, 13'h012, 8'h77);
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_rdata", 32'(rsp_rdata), 32'h5A);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rd_hold_valid", 32'(rsp_valid), 32'd1);
      check("rd_hold_rdata", 32'(rsp_rdata), 32'h5A);
      check("rd_hold_block", 32'(c_en),      32'd0);
    end
    rsp_ready = 1'b1;
    step();
    check("rd_rsp_clear", 32'(rsp_valid), 32'd0);
    wait_en("rd_next_issue");
    check("rd_next_addr", 32'(c_addr), 32'h012);
    for (int i = 0; i < 4; i++) step();

    // full / back-pressure, then in-order drain
    c_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(1'b1, 13'(32'h100 + i), 8'(32'hA0 + i));
      if (i == 3) begin
        check("full_ready", 32'(req_ready), 32'd0);
        check("full_count", 32'(q_count),   32'd4);
      end
    end
    check("full_drop_5th", 32'(q_count), 32'd4);
    c_busy = 1'b0;
    wait_en("drain_first_issue");
    check("drain_first_addr", 32'(c_addr), 32'h100);
    for (int i = 0; i < 14; i++) step();
    check("drain_empty", 32'(q_count), 32'd0);

    // push coinciding with the pop of the only entry
    push(1'b1, 13'h0AA, 8'h11);
    step(); step();
    check("pp_ack_pending", 32'(c_cmd_ack), 32'd1);
    push(1'b1, 13'h0BB, 8'h22);
    check("pp_count_same", 32'(q_count), 32'd1);
    for (int i = 0; i < 6; i++) step();

    // read timeout
    rd_lat = 0;
    push(1'b0, 13'h777, 8'h00);
    push(1'b1, 13'h042, 8'h99);
    wait_ack("to_ack");
    step();
    for (int i = 0; i < TMO - 1; i++) step();
    check("to_not_early", 32'(rsp_valid), 32'd0);
    step();
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_rsp_err",   32'(rsp_err),   32'd1);
    check("to_rsp_rdata", 32'(rsp_rdata), 32'd0);
    wait_en("to_next_issue");
    check("to_next_addr",  32'(c_addr),  32'h042);
    check("to_next_wdata", 32'(c_wdata), 32'h99);
    for (int i = 0; i < 4; i++) step();

    // reset while waiting on a read
    push(1'b0, 13'h123, 8'h00);
    push(1'b1, 13'h0CC, 8'h44);
    wait_ack("mr_ack");
    step(); step(); step(); step();
    u_rst = 1'b1;
    step();
    u_rst    = 1'b0;
    dv_pulse = 1;
    step(); step(); step();
    check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mr_q_count",   32'(q_count),   32'd0);
    check("mr_rsp_err",   32'(rsp_err),   32'd0);
    check("mr_c_en",      32'(c_en),      32'd0);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
